// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
//   Parametrised multi-port register file with same-cycle write-to-read
//   bypass and a per-register busy scoreboard for writeback hazard stalls.
//
// Ports
//   clk       rising-edge clock
//   nRst      asynchronous active-low reset (clears data, busy, outputs)
//   wen       per-port write enable             [NWRITE]
//   wsel      per-port write select             [NWRITE][ADDR_W]
//   wdat      per-port write data               [NWRITE][DATA_W]
//   rsel      per-port read select              [NREAD][ADDR_W]
//   rdat      per-port read data, combinational [NREAD][DATA_W]
//   rbusy     per-port busy of selected reg     [NREAD]
//   rsv_en    reserve rsv_sel (mark busy)
//   rsv_sel   register to reserve
//   flush     synchronous clear of all busy bits
//   any_busy  registered OR of all busy bits
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                           clk,
  input  logic                           nRst,
  input  logic [NWRITE-1:0]              wen,
  input  logic [NWRITE-1:0][ADDR_W-1:0]  wsel,
  input  logic [NWRITE-1:0][DATA_W-1:0]  wdat,
  input  logic [NREAD-1:0][ADDR_W-1:0]   rsel,
  output logic [NREAD-1:0][DATA_W-1:0]   rdat,
  output logic [NREAD-1:0]               rbusy,
  input  logic                           rsv_en,
  input  logic [ADDR_W-1:0]              rsv_sel,
  input  logic                           flush,
  output logic                           any_busy
);

  // One extra bit so DEPTH == 2**ADDR_W is representable; the full select is
  // compared, so out-of-range indices never alias onto implemented registers.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
    return ({1'b0, idx} < DEPTH_L) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [NWRITE-1:0] wv;

  always_comb begin
    wv = '0;
    for (int unsigned i = 0; i < NWRITE; i++) begin
      wv[i] = wen[i] & idx_ok(wsel[i]);
    end
  end

  // Data array: ports are scanned in ascending order so the highest-index
  // port wins a same-register collision.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        regs[j] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        for (int unsigned i = 0; i < NWRITE; i++) begin
          if (wv[i] && (wsel[i] == ADDR_W'(j))) begin
            regs[j] <= wdat[i];
          end
        end
      end
    end
  end

  // Scoreboard next state: write clears, reservation then overrides the
  // clear (new producer pending), flush overrides everything.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      for (int unsigned i = 0; i < NWRITE; i++) begin
        if (wv[i] && (wsel[i] == ADDR_W'(j))) begin
          busy_nxt[j] = 1'b0;
        end
      end
      if (rsv_en && idx_ok(rsv_sel) && (rsv_sel == ADDR_W'(j))) begin
        busy_nxt[j] = 1'b1;
      end
    end
    if (flush) begin
      busy_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      busy     <= '0;
      any_busy <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      any_busy <= |busy_nxt;
    end
  end

  // Read ports: array lookup, invalid-index masking, then bypass from the
  // highest-index matching write. Outputs are forced to 0 while in reset so
  // write data presented during reset is never forwarded.
  always_comb begin
    for (int unsigned k = 0; k < NREAD; k++) begin
      rdat[k]  = '0;
      rbusy[k] = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (rsel[k] == ADDR_W'(j)) begin
          rdat[k]  = regs[j];
          rbusy[k] = busy[j];
        end
      end
      if (!idx_ok(rsel[k])) begin
        rdat[k]  = '0;
        rbusy[k] = 1'b0;
      end
      if (BYPASS != 0) begin
        for (int unsigned i = 0; i < NWRITE; i++) begin
          if (wv[i] && (wsel[i] == rsel[k])) begin
            rdat[k]  = wdat[i];
            rbusy[k] = 1'b0;
          end
        end
      end
      if (!nRst) begin
        rdat[k]  = '0;
        rbusy[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb. Two instances share all inputs:
//   dut_a : defaults (DEPTH=32, BYPASS=1)
//   dut_b : DEPTH=16, BYPASS=0
module tb_regfile_mp_sb;

  logic              clk;
  logic              nRst;
  logic [1:0]        wen;
  logic [1:0][4:0]   wsel;
  logic [1:0][31:0]  wdat;
  logic [1:0][4:0]   rsel;
  logic              rsv_en;
  logic [4:0]        rsv_sel;
  logic              flush;

  logic [1:0][31:0]  a_rdat, b_rdat;
  logic [1:0]        a_rbusy, b_rbusy;
  logic              a_any, b_any;

  int vectors = 0;
  int miscompares = 0;

  regfile_mp_sb dut_a (
    .clk(clk), .nRst(nRst), .wen(wen), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(a_rdat), .rbusy(a_rbusy), .rsv_en(rsv_en),
    .rsv_sel(rsv_sel), .flush(flush), .any_busy(a_any)
  );

  regfile_mp_sb #(.DEPTH(16), .BYPASS(0)) dut_b (
    .clk(clk), .nRst(nRst), .wen(wen), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(b_rdat), .rbusy(b_rbusy), .rsv_en(rsv_en),
    .rsv_sel(rsv_sel), .flush(flush), .any_busy(b_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wen = '0; wsel = '0; wdat = '0; rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rsel = '0;
    nRst = 1'b1;
    #1 nRst = 1'b0;
    wen[0] = 1'b1; wsel[0] = 5'd5; wdat[0] = 32'hDEADBEEF;
    rsel[0] = 5'd5; rsel[1] = 5'd5;
    rsv_en = 1'b1; rsv_sel = 5'd5;
    #1;
    vectors++; if (a_rdat[0] !== 32'h0) begin miscompares++; $display("FAIL reset_rdat_a: got %h want %h", a_rdat[0], 32'h0); end
    vectors++; if (b_rdat[1] !== 32'h0) begin miscompares++; $display("FAIL reset_rdat_b: got %h want %h", b_rdat[1], 32'h0); end
    vectors++; if (a_rbusy !== 2'b00) begin miscompares++; $display("FAIL reset_rbusy: got %b want %b", a_rbusy, 2'b00); end
    step();
    vectors++; if (a_rdat[0] !== 32'h0) begin miscompares++; $display("FAIL reset_hold_rdat: got %h want %h", a_rdat[0], 32'h0); end
    vectors++; if (a_any !== 1'b0) begin miscompares++; $display("FAIL reset_any_busy: got %b want %b", a_any, 1'b0); end
    idle();
    nRst = 1'b1;
    #1;
    vectors++; if (a_rdat[0] !== 32'h0) begin miscompares++; $display("FAIL reset_write_dropped: got %h want %h", a_rdat[0], 32'h0); end
    // r0 is hardwired: write and reserve must have no visible effect
    wen[0] = 1'b1; wsel[0] = 5'd0; wdat[0] = 32'h1234;
    rsv_en = 1'b1; rsv_sel = 5'd0;
    rsel[0] = 5'd0;
    #1;
    vectors++; if (a_rdat[0] !== 32'h0) begin miscompares++; $display("FAIL r0_bypass: got %h want %h", a_rdat[0], 32'h0); end
    step();
    idle();
    #1;
    vectors++; if (a_rdat[0] !== 32'h0) begin miscompares++; $display("FAIL r0_read: got %h want %h", a_rdat[0], 32'h0); end
    vectors++; if (a_rbusy[0] !== 1'b0) begin miscompares++; $display("FAIL r0_busy: got %b want %b", a_rbusy[0], 1'b0); end
    vectors++; if (a_any !== 1'b0) begin miscompares++; $display("FAIL r0_any_busy: got %b want %b", a_any, 1'b0); end
  endtask

  task automatic test_basic_write();
    idle();
    wen[0] = 1'b1; wsel[0] = 5'd3; wdat[0] = 32'hA5A5A5A5;
    rsel[0] = 5'd3;
    #1;
    vectors++; if (a_rdat[0] !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL basic_bypass: got %h want %h", a_rdat[0], 32'hA5A5A5A5); end
    vectors++; if (b_rdat[0] !== 32'h0) begin miscompares++; $display("FAIL basic_nobypass_old: got %h want %h", b_rdat[0], 32'h0); end
    step();
    idle();
    #1;
    vectors++; if (a_rdat[0] !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL basic_read_a: got %h want %h", a_rdat[0], 32'hA5A5A5A5); end
    vectors++; if (b_rdat[0] !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL basic_read_b: got %h want %h", b_rdat[0], 32'hA5A5A5A5); end
  endtask

  task automatic test_write_conflict();
    idle();
    wen = 2'b11;
    wsel[0] = 5'd7; wdat[0] = 32'h11;
    wsel[1] = 5'd7; wdat[1] = 32'h22;
    rsel[1] = 5'd7;
    #1;
    vectors++; if (a_rdat[1] !== 32'h22) begin miscompares++; $display("FAIL conflict_bypass: got %h want %h", a_rdat[1], 32'h22); end
    vectors++; if (b_rdat[1] !== 32'h0) begin miscompares++; $display("FAIL conflict_nobypass: got %h want %h", b_rdat[1], 32'h0); end
    step();
    idle();
    #1;
    vectors++; if (a_rdat[1] !== 32'h22) begin miscompares++; $display("FAIL conflict_read_a: got %h want %h", a_rdat[1], 32'h22); end
    vectors++; if (b_rdat[1] !== 32'h22) begin miscompares++; $display("FAIL conflict_read_b: got %h want %h", b_rdat[1], 32'h22); end
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_sel = 5'd9;
    rsel[0] = 5'd9;
    #1;
    vectors++; if (a_rbusy[0] !== 1'b0) begin miscompares++; $display("FAIL sb_same_cycle: got %b want %b", a_rbusy[0], 1'b0); end
    step();
    idle();
    #1;
    vectors++; if (a_rbusy[0] !== 1'b1) begin miscompares++; $display("FAIL sb_busy_a: got %b want %b", a_rbusy[0], 1'b1); end
    vectors++; if (b_rbusy[0] !== 1'b1) begin miscompares++; $display("FAIL sb_busy_b: got %b want %b", b_rbusy[0], 1'b1); end
    vectors++; if (a_any !== 1'b1) begin miscompares++; $display("FAIL sb_any_set: got %b want %b", a_any, 1'b1); end
    wen[1] = 1'b1; wsel[1] = 5'd9; wdat[1] = 32'h55;
    #1;
    vectors++; if (a_rbusy[0] !== 1'b0) begin miscompares++; $display("FAIL sb_bypass_clear: got %b want %b", a_rbusy[0], 1'b0); end
    vectors++; if (b_rbusy[0] !== 1'b1) begin miscompares++; $display("FAIL sb_nobypass_busy: got %b want %b", b_rbusy[0], 1'b1); end
    vectors++; if (a_rdat[0] !== 32'h55) begin miscompares++; $display("FAIL sb_bypass_data: got %h want %h", a_rdat[0], 32'h55); end
    step();
    idle();
    #1;
    vectors++; if (a_rbusy[0] !== 1'b0) begin miscompares++; $display("FAIL sb_cleared: got %b want %b", a_rbusy[0], 1'b0); end
    vectors++; if (a_any !== 1'b0) begin miscompares++; $display("FAIL sb_any_clear_a: got %b want %b", a_any, 1'b0); end
    vectors++; if (b_any !== 1'b0) begin miscompares++; $display("FAIL sb_any_clear_b: got %b want %b", b_any, 1'b0); end
  endtask

  task automatic test_simultaneous();
    idle();
    rsv_en = 1'b1; rsv_sel = 5'd4;
    wen[0] = 1'b1; wsel[0] = 5'd4; wdat[0] = 32'h99;
    rsel[0] = 5'd4;
    step();
    idle();
    #1;
    vectors++; if (a_rdat[0] !== 32'h99) begin miscompares++; $display("FAIL sim_rsv_wr_data: got %h want %h", a_rdat[0], 32'h99); end
    vectors++; if (a_rbusy[0] !== 1'b1) begin miscompares++; $display("FAIL sim_rsv_wins: got %b want %b", a_rbusy[0], 1'b1); end
    vectors++; if (a_any !== 1'b1) begin miscompares++; $display("FAIL sim_any: got %b want %b", a_any, 1'b1); end
    rsv_en = 1'b1; rsv_sel = 5'd6; flush = 1'b1;
    wen[0] = 1'b1; wsel[0] = 5'd2; wdat[0] = 32'h77;
    step();
    idle();
    rsel[0] = 5'd6; rsel[1] = 5'd2;
    #1;
    vectors++; if (a_rbusy[0] !== 1'b0) begin miscompares++; $display("FAIL flush_rsv: got %b want %b", a_rbusy[0], 1'b0); end
    vectors++; if (a_any !== 1'b0) begin miscompares++; $display("FAIL flush_any: got %b want %b", a_any, 1'b0); end
    vectors++; if (a_rdat[1] !== 32'h77) begin miscompares++; $display("FAIL flush_write_commits: got %h want %h", a_rdat[1], 32'h77); end
    rsel[1] = 5'd4;
    #1;
    vectors++; if (a_rbusy[1] !== 1'b0) begin miscompares++; $display("FAIL flush_r4: got %b want %b", a_rbusy[1], 1'b0); end
  endtask

  task automatic test_boundary();
    idle();
    wen = 2'b11;
    wsel[0] = 5'd20; wdat[0] = 32'hFF;
    wsel[1] = 5'd15; wdat[1] = 32'hFF;
    rsv_en = 1'b1; rsv_sel = 5'd20;
    rsel[0] = 5'd20; rsel[1] = 5'd15;
    #1;
    vectors++; if (b_rdat[0] !== 32'h0) begin miscompares++; $display("FAIL bnd_r20_b_now: got %h want %h", b_rdat[0], 32'h0); end
    vectors++; if (a_rdat[0] !== 32'hFF) begin miscompares++; $display("FAIL bnd_r20_a_bypass: got %h want %h", a_rdat[0], 32'hFF); end
    step();
    idle();
    #1;
    vectors++; if (b_rdat[0] !== 32'h0) begin miscompares++; $display("FAIL bnd_r20_b: got %h want %h", b_rdat[0], 32'h0); end
    vectors++; if (b_rbusy[0] !== 1'b0) begin miscompares++; $display("FAIL bnd_r20_b_busy: got %b want %b", b_rbusy[0], 1'b0); end
    vectors++; if (b_any !== 1'b0) begin miscompares++; $display("FAIL bnd_b_any: got %b want %b", b_any, 1'b0); end
    vectors++; if (b_rdat[1] !== 32'hFF) begin miscompares++; $display("FAIL bnd_r15_b: got %h want %h", b_rdat[1], 32'hFF); end
    vectors++; if (a_rbusy[0] !== 1'b1) begin miscompares++; $display("FAIL bnd_r20_a_busy: got %b want %b", a_rbusy[0], 1'b1); end
    // r20 must not alias onto r4 in the 16-entry instance
    rsel[0] = 5'd4;
    #1;
    vectors++; if (b_rdat[0] !== 32'h99) begin miscompares++; $display("FAIL bnd_no_alias: got %h want %h", b_rdat[0], 32'h99); end
    rsv_en = 1'b1; rsv_sel = 5'd11;
    step();
    idle();
    rsel[0] = 5'd11;
    #1;
    vectors++; if (b_rbusy[0] !== 1'b1) begin miscompares++; $display("FAIL bnd_r11_busy: got %b want %b", b_rbusy[0], 1'b1); end
    rsv_en = 1'b1; rsv_sel = 5'd12;
    nRst = 1'b0;
    #1;
    vectors++; if (a_any !== 1'b0) begin miscompares++; $display("FAIL rst_mid_any_a: got %b want %b", a_any, 1'b0); end
    vectors++; if (b_any !== 1'b0) begin miscompares++; $display("FAIL rst_mid_any_b: got %b want %b", b_any, 1'b0); end
    vectors++; if (b_rbusy[0] !== 1'b0) begin miscompares++; $display("FAIL rst_mid_rbusy: got %b want %b", b_rbusy[0], 1'b0); end
    step();
    idle();
    nRst = 1'b1;
    rsel[0] = 5'd12; rsel[1] = 5'd15;
    #1;
    vectors++; if (b_rdat[1] !== 32'h0) begin miscompares++; $display("FAIL rst_mid_data: got %h want %h", b_rdat[1], 32'h0); end
    step();
    vectors++; if (a_rbusy[0] !== 1'b0) begin miscompares++; $display("FAIL rst_mid_rsv_dropped: got %b want %b", a_rbusy[0], 1'b0); end
    vectors++; if (a_any !== 1'b0) begin miscompares++; $display("FAIL rst_mid_any_after: got %b want %b", a_any, 1'b0); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_write_conflict();
    test_scoreboard();
    test_simultaneous();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
